fdiv_iter: RTL and testbench

- Iterative single-precision floating-point divider, result = op1 / op2. It is the inverse companion to fmul in the FPU.
- Radix-2 restoring mantissa division runs one quotient bit per cycle, with a valid/ready handshake on input and output.
- Same number conventions as fmul: denormals flushed to zero, round-to-nearest-even, no exception flags.
- Built for both random-vector and directed-vector benches.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fdiv_round.sv | 52 +++++
 rtl/fdiv_iter.sv | 160 ++++++++++++++++
 tb/tb_fdiv_iter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, canonical constants,
// operand decode and the divider state encoding.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Working exponent: wide and signed so e1 - e2 + bias never wraps.
  typedef logic signed [9:0] exp_calc_t;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  function automatic fp_class_e classify(input fp32_t x);
    if (x.exp == '0)       return CLS_ZERO;
    else if (x.exp == '1)  return (x.frac == '0) ? CLS_INF : CLS_NAN;
    else                   return CLS_NORM;
  endfunction

endpackage

// File: rtl/fdiv_round.sv
// Normalizes the raw quotient, applies round-to-nearest-even and clamps the
// exponent to +-inf on overflow and +-0 on underflow (no denormal output).
module fdiv_round
  import fpu_pkg::*;
(
  input  logic        sign,
  input  exp_calc_t   exp_in,
  input  logic [25:0] quo,
  input  logic        rem_nz,
  output logic [31:0] result
);

  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [24:0]       mant_rnd;
  logic [FRAC_W-1:0] frac;
  exp_calc_t         exp_n;
  exp_calc_t         exp_f;

  always_comb begin
    // Quotient lies in (0.5, 2): either the integer bit is set or the next one is.
    if (quo[25]) begin
      mant   = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | rem_nz;
      exp_n  = exp_in;
    end else begin
      mant   = quo[24:1];
      guard  = quo[0];
      sticky = rem_nz;
      exp_n  = exp_in - 10'sd1;
    end

    inc      = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + 25'(inc);

    if (mant_rnd[24]) begin
      exp_f = exp_n + 10'sd1;
      frac  = mant_rnd[23:1];
    end else begin
      exp_f = exp_n;
      frac  = mant_rnd[22:0];
    end

    if (exp_f >= 10'sd255)     result = {sign, POS_INF[30:0]};
    else if (exp_f <= 10'sd0)  result = {sign, 31'h0};
    else                       result = {sign, exp_f[7:0], frac};
  end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per cycle, valid/ready handshake on both sides.
module fdiv_iter
  import fpu_pkg::*;
#(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(QBITS);

  state_e           state_q,     state_d;
  logic             sign_q,      sign_d;
  exp_calc_t        exp_q,       exp_d;
  logic [24:0]      div_q,       div_d;
  logic [24:0]      rem_q,       rem_d;
  logic [QBITS-1:0] quo_q,       quo_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      result_q,    result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;

  fp32_t       fp1, fp2;
  fp_class_e   cls1, cls2;
  logic        sign_x;
  logic [25:0] two_r;
  logic [31:0] round_res;

  assign fp1    = fp32_t'(op1);
  assign fp2    = fp32_t'(op2);
  assign cls1   = classify(fp1);
  assign cls2   = classify(fp2);
  assign sign_x = fp1.sign ^ fp2.sign;
  assign two_r  = {rem_q, 1'b0};

  fdiv_round u_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .quo    (quo_q),
    .rem_nz (|rem_q),
    .result (round_res)
  );

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = sign_x;
          in_ready_d = 1'b0;
          if (cls1 == CLS_NAN || cls2 == CLS_NAN ||
              (cls1 == CLS_ZERO && cls2 == CLS_ZERO) ||
              (cls1 == CLS_INF  && cls2 == CLS_INF)) begin
            result_d    = QNAN;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (cls1 == CLS_INF || cls2 == CLS_ZERO) begin
            result_d    = {sign_x, POS_INF[30:0]};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (cls1 == CLS_ZERO || cls2 == CLS_INF) begin
            result_d    = {sign_x, 31'h0};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            exp_d = {2'b00, fp1.exp} - {2'b00, fp2.exp} + 10'(EXP_BIAS);
            // Divisor is pre-doubled so the first 2r >= d test yields the integer bit.
            rem_d   = {1'b0, 1'b1, fp1.frac};
            div_d   = {1'b1, fp2.frac, 1'b0};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end

      DIV: begin
        if (two_r >= {1'b0, div_q}) begin
          rem_d = 25'(two_r - {1'b0, div_q});
          quo_d = {quo_q[QBITS-2:0], 1'b1};
        end else begin
          rem_d = two_r[24:0];
          quo_d = {quo_q[QBITS-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(QBITS - 1)) state_d = NORM;
      end

      NORM: begin
        result_d    = round_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would create order-dependent simulation races.
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed vectors with fixed expectations,
// then random operands against an exact-integer division reference model.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op1, op2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  fdiv_iter #(.QBITS(26)) dut (
    .clk       (clk),
    .reset     (reset),
    .op1       (op1),
    .op2       (op2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Exact quotient by integer division, then RNE on the true remainder.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit special);
    int     ea, eb, e, sh;
    bit     s, za, zb, ia, ib, na, nb;
    longint num, den, q, rem, mant, lost, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    special = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) r = 32'h7FC00000;
    else if (ia || zb)                        r = {s, 8'hFF, 23'h0};
    else if (za || ib)                        r = {s, 31'h0};
    else begin
      special = 1'b0;
      num = longint'({1'b1, a[22:0]}) << 38;
      den = longint'({1'b1, b[22:0]});
      q   = num / den;
      rem = num % den;
      e   = ea - eb + 127;
      if (q >= (longint'(1) << 38)) sh = 15;
      else begin
        sh = 14;
        e  = e - 1;
      end
      mant = q >> sh;
      lost = q - (mant << sh);
      half = longint'(1) << (sh - 1);
      if (lost > half || (lost == half && (rem != 0 || mant[0]))) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= 255)     r = {s, 8'hFF, 23'h0};
      else if (e <= 0)  r = {s, 31'h0};
      else              r = {s, 8'(e), 23'(mant)};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    int          sel;
    logic [7:0]  e;
    sel = int'($urandom_range(0, 19));
    if (sel == 0)       e = 8'h00;
    else if (sel <= 2)  e = 8'hFF;
    else                e = 8'($urandom_range(1, 254));
    if (sel == 1) return {1'($urandom), e, 23'h0};
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int want_lat,
                        input int hold, input bit scramble);
    int lat;
    bit busy_ready;
    @(negedge clk);
    check($sformatf("%s idle in_ready", tag), 32'(in_ready), 32'd1);
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid   = 1'b0;
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1'b1;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(want_lat));
    check($sformatf("%s result", tag), result, want);
    check($sformatf("%s in_ready busy", tag), 32'(busy_ready), 32'd0);
    check($sformatf("%s in_ready done", tag), 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s held result", tag), result, want);
      check($sformatf("%s held out_valid", tag), 32'(out_valid), 32'd1);
      check($sformatf("%s held in_ready", tag), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s out_valid drop", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s in_ready back", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, want;
    bit          sp;

    reset     = 1'b0;
    op1       = '0;
    op2       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    run_op("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 28, 0, 1'b0);
    run_op("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 0, 1'b0);
    run_op("1/1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 28, 0, 1'b0);
    run_op("0/-2",       32'h00000000, 32'hC0000000, 32'h80000000,  1, 0, 1'b0);
    run_op("1/0",        32'h3F800000, 32'h00000000, 32'h7F800000,  1, 0, 1'b0);
    run_op("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000,  1, 0, 1'b0);
    run_op("inf/inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000,  1, 0, 1'b0);
    run_op("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000,  1, 0, 1'b0);
    run_op("2/-inf",     32'h40000000, 32'hFF800000, 32'h80000000,  1, 0, 1'b0);
    run_op("ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 28, 0, 1'b0);
    run_op("unf",        32'h00800000, 32'h40000000, 32'h00000000, 28, 0, 1'b0);
    run_op("neg ovf",    32'hFF000000, 32'h3E800000, 32'hFF800000, 28, 0, 1'b0);
    run_op("backpress",  32'h40C00000, 32'h40000000, 32'h40400000, 28, 5, 1'b1);

    // Reset while the divider is mid-iteration.
    @(negedge clk);
    op1      = 32'h40C00000;
    op2      = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    run_op("10/5", 32'h41200000, 32'h40A00000, 32'h40000000, 28, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      a = rand_fp();
      b = rand_fp();
      ref_div(a, b, want, sp);
      run_op($sformatf("rnd%0d %h/%h", i, a, b), a, b, want, sp ? 1 : 28,
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
